// File: rtl/edge_detect_seq.sv
// Sequencer for the EdgeDetection core: loads one framed image over valid/ready,
// then switches the core to readout and forwards edge values until complete.
module edge_detect_seq #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NPIX     = 4096,
  parameter int unsigned WD_SLACK = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              core_enb,
  output logic              core_mode_buf,
  output logic              core_reset_buf,
  output logic [DATA_W-1:0] core_pix,
  input  logic [DATA_W-1:0] core_edges,
  input  logic              core_complete,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned   DRAIN_MAX = NPIX + WD_SLACK;
  localparam int unsigned   CW        = $clog2(DRAIN_MAX + 1);
  localparam logic [CW-1:0] CNT_SAT   = CW'(DRAIN_MAX);
  localparam logic [CW-1:0] PIX_LAST  = CW'(NPIX - 1);
  localparam logic [CW-1:0] DRN_LAST  = CW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, TURN, DRAIN, FINISH} state_t;

  state_t            state, state_n;
  logic              clr_to_idle, clr_to_idle_n;
  logic [CW-1:0]     pix_cnt, pix_cnt_n;
  logic [CW-1:0]     drn_cnt, drn_cnt_n;
  logic              enb_n, mode_n, rbuf_n, ov_n, done_n, err_n;
  logic [DATA_W-1:0] pix_n, od_n;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_SAT) ? v : v + CW'(1);
  endfunction

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);

  always_comb begin
    state_n       = state;
    clr_to_idle_n = clr_to_idle;
    pix_cnt_n     = pix_cnt;
    drn_cnt_n     = drn_cnt;
    enb_n         = 1'b0;
    mode_n        = core_mode_buf;
    pix_n         = core_pix;
    ov_n          = 1'b0;
    od_n          = out_data;
    done_n        = 1'b0;
    err_n         = error;

    case (state)
      IDLE: begin
        mode_n = 1'b0;
        if (start && !abort) begin
          state_n       = CLEAR;
          clr_to_idle_n = 1'b0;
          err_n         = 1'b0;
          pix_cnt_n     = '0;
          drn_cnt_n     = '0;
        end
      end
      CLEAR: begin
        mode_n        = 1'b0;
        clr_to_idle_n = 1'b0;
        state_n       = clr_to_idle ? IDLE : LOAD;
      end
      LOAD: begin
        mode_n = 1'b0;
        if (in_valid) begin
          pix_n     = in_data;
          enb_n     = 1'b1;
          pix_cnt_n = sat_inc(pix_cnt);
          if (pix_cnt == PIX_LAST) state_n = TURN;
        end
      end
      TURN: begin
        mode_n  = 1'b1;
        state_n = DRAIN;
      end
      DRAIN: begin
        mode_n = 1'b1;
        enb_n  = 1'b1;
        // The first DRAIN cycle still has enb low from TURN, so the core has not
        // produced a read yet; only cycles where the core was enabled are forwarded.
        if (core_complete) begin
          enb_n   = 1'b0;
          state_n = FINISH;
        end else if (core_enb) begin
          ov_n      = 1'b1;
          od_n      = core_edges;
          drn_cnt_n = sat_inc(drn_cnt);
          if (drn_cnt == DRN_LAST) begin
            err_n   = 1'b1;
            enb_n   = 1'b0;
            state_n = FINISH;
          end
        end
      end
      FINISH: begin
        mode_n  = 1'b0;
        done_n  = !error;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort && (state != IDLE)) begin
      state_n       = CLEAR;
      clr_to_idle_n = 1'b1;
      enb_n         = 1'b0;
      mode_n        = 1'b0;
      pix_n         = core_pix;
      ov_n          = 1'b0;
      od_n          = out_data;
      done_n        = 1'b0;
      err_n         = error;
    end

    rbuf_n = (state_n == CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      clr_to_idle    <= 1'b0;
      pix_cnt        <= '0;
      drn_cnt        <= '0;
      core_enb       <= 1'b0;
      core_mode_buf  <= 1'b0;
      core_reset_buf <= 1'b1;
      core_pix       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state          <= state_n;
      clr_to_idle    <= clr_to_idle_n;
      pix_cnt        <= pix_cnt_n;
      drn_cnt        <= drn_cnt_n;
      core_enb       <= enb_n;
      core_mode_buf  <= mode_n;
      core_reset_buf <= rbuf_n;
      core_pix       <= pix_n;
      out_valid      <= ov_n;
      out_data       <= od_n;
      done           <= done_n;
      error          <= err_n;
    end
  end

endmodule

// File: tb/tb_edge_detect_seq.sv
// Directed bench for edge_detect_seq with a small behavioural EdgeDetection core:
// edges = stored pixel ^ 8'h5A at the read pointer, complete after NPIX reads.
module tb_edge_detect_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 16;
  localparam int unsigned WS = 4;

  logic          clk = 1'b0;
  logic          reset, start, abort, in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready, core_enb, core_mode_buf, core_reset_buf;
  logic [DW-1:0] core_pix, core_edges, out_data;
  logic          core_complete, out_valid, busy, done, error;
  logic          no_complete;

  always #5 clk = ~clk;

  edge_detect_seq #(.DATA_W(DW), .NPIX(NP), .WD_SLACK(WS)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_enb(core_enb), .core_mode_buf(core_mode_buf),
    .core_reset_buf(core_reset_buf), .core_pix(core_pix),
    .core_edges(core_edges), .core_complete(core_complete),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .error(error)
  );

  // Behavioural core
  logic [DW-1:0] mem [NP];
  logic [3:0]    wr_ptr = '0;
  logic [5:0]    rd_ptr = '0;

  always @(posedge clk) begin
    if (core_reset_buf) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (core_enb) begin
      if (!core_mode_buf) begin
        mem[wr_ptr] <= core_pix;
        wr_ptr      <= wr_ptr + 4'd1;
      end else begin
        rd_ptr <= rd_ptr + 6'd1;
      end
    end
  end

  assign core_edges    = mem[rd_ptr[3:0]] ^ 8'h5A;
  assign core_complete = !no_complete && (rd_ptr == 6'd16);

  // Output monitor
  int unsigned   n_load = 0, n_beat = 0, n_done = 0, n_rbuf = 0;
  int unsigned   n_err_enb = 0, n_mode_viol = 0;
  logic [DW-1:0] beat_log [256];
  logic          acc_q = 1'b0, mode_q = 1'b0;

  always @(posedge clk) acc_q <= in_valid & in_ready & ~abort;

  always @(negedge clk) begin
    if (core_enb && !core_mode_buf) n_load <= n_load + 1;
    if (out_valid) begin
      beat_log[n_beat % 256] <= out_data;
      n_beat <= n_beat + 1;
    end
    if (done) n_done <= n_done + 1;
    if (core_reset_buf) n_rbuf <= n_rbuf + 1;
    if (!core_mode_buf && (core_enb != acc_q)) n_err_enb <= n_err_enb + 1;
    if ((core_mode_buf != mode_q) && core_enb) n_mode_viol <= n_mode_viol + 1;
    mode_q <= core_mode_buf;
  end

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic feed_image(input int unsigned stall_period, input logic [7:0] base,
                            input int unsigned abort_after, input bit poke);
    int unsigned sent, k;
    bit acc;
    sent = 0;
    k = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (sent < NP && k < 200) begin
      if (abort_after != 0 && sent == abort_after) begin
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        return;
      end
      in_valid = !(stall_period != 0 && (k % stall_period) == stall_period - 1);
      in_data  = base + 8'(sent);
      start    = poke && (k == 6);
      acc      = in_valid && in_ready;
      @(negedge clk);
      if (acc) sent++;
      k++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check_eq("feed_timeout", 32'(k < 200), 1);
  endtask

  task automatic wait_idle(input bit poke);
    int unsigned cyc;
    cyc = 0;
    while (busy && cyc < 200) begin
      start = poke && (cyc == 8);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check_eq("idle_timeout", 32'(cyc < 200), 1);
    @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input int unsigned stall,
                               input logic [7:0] base, input bit poke);
    int unsigned l0, b0, d0, r0;
    logic [7:0]  exp8;
    l0 = n_load; b0 = n_beat; d0 = n_done; r0 = n_rbuf;
    feed_image(stall, base, 0, poke);
    wait_idle(poke);
    check_eq({tag, "_loads"}, n_load - l0, NP);
    check_eq({tag, "_beats"}, n_beat - b0, NP);
    for (int i = 0; i < NP; i++) begin
      exp8 = (base + 8'(i)) ^ 8'h5A;
      check_eq({tag, "_beat"}, beat_log[(b0 + i) % 256], exp8);
    end
    check_eq({tag, "_done"}, n_done - d0, 1);
    check_eq({tag, "_error"}, error, 0);
    check_eq({tag, "_rbuf"}, n_rbuf - r0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: still running at %0t, required earlier finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned l0, b0, d0, r0;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; no_complete = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_rbuf", core_reset_buf, 1);
    check_eq("rst_enb", core_enb, 0);
    check_eq("rst_mode", core_mode_buf, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", in_ready, 0);
    check_eq("rst_pix", core_pix, 0);
    check_eq("rst_odata", out_data, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_rbuf", core_reset_buf, 0);
    check_eq("rel_busy", busy, 0);

    run_and_check("basic", 0, 8'h10, 1'b0);
    run_and_check("stall", 3, 8'h40, 1'b0);

    no_complete = 1'b1;
    b0 = n_beat; d0 = n_done;
    feed_image(0, 8'h70, 0, 1'b0);
    wait_idle(1'b0);
    no_complete = 1'b0;
    check_eq("wd_beats", n_beat - b0, NP + WS);
    check_eq("wd_done", n_done - d0, 0);
    check_eq("wd_error", error, 1);
    check_eq("wd_busy", busy, 0);

    l0 = n_load; d0 = n_done; r0 = n_rbuf;
    feed_image(0, 8'h90, 7, 1'b0);
    check_eq("abort_rbuf_hi", core_reset_buf, 1);
    check_eq("abort_ready", in_ready, 0);
    check_eq("abort_enb", core_enb, 0);
    @(negedge clk);
    check_eq("abort_idle", busy, 0);
    check_eq("abort_rbuf_lo", core_reset_buf, 0);
    @(negedge clk);
    check_eq("abort_rbuf_pulses", n_rbuf - r0, 2);
    check_eq("abort_loads", n_load - l0, 7);
    check_eq("abort_done", n_done - d0, 0);
    check_eq("abort_error", error, 0);
    run_and_check("reload", 0, 8'hA0, 1'b0);

    feed_image(0, 8'hC0, 0, 1'b0);
    repeat (6) @(negedge clk);
    check_eq("drain_valid", out_valid, 1);
    d0 = n_done;
    #2 reset = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_enb", core_enb, 0);
    check_eq("arst_mode", core_mode_buf, 0);
    check_eq("arst_rbuf", core_reset_buf, 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_odata", out_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("arst_no_done", n_done - d0, 0);
    check_eq("arst_rbuf_rel", core_reset_buf, 0);

    run_and_check("b2b_a", 0, 8'hD0, 1'b0);
    run_and_check("b2b_poke", 3, 8'hE3, 1'b1);

    r0 = n_rbuf;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("sa_idle_busy", busy, 0);
    check_eq("sa_idle_rbuf", n_rbuf - r0, 0);

    check_eq("enb_follows_accept", n_err_enb, 0);
    check_eq("mode_change_with_enb", n_mode_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_detect_seq.md
# edge_detect_seq

Sequencer for the `EdgeDetection` core. It accepts a framed pixel stream over a valid/ready handshake and loads one image into the core's buffer (`modeBuffer=0`). It then switches the core to readout (`modeBuffer=1`) and forwards edge values downstream until the core raises `complete`. It sits between the pixel source and `EdgeDetection`, owning every `enb`/`modeBuffer`/`resetBuff` decision that benches currently drive by hand.

## Interface
- `DATA_W`, 8, pixel and edge width
- `NPIX`, 4096, pixels per image (>=2)
- `WD_SLACK`, 64, extra drain cycles allowed beyond `NPIX` before watchdog error
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin one image; sampled only in IDLE
- `abort`  in  1  synchronous; returns to IDLE from any state
- `in_valid`  in  1  input pixel valid
- `in_data`  in  DATA_W  input pixel
- `in_ready`  out  1  sequencer accepts pixel this cycle
- `core_enb`  out  1  to core `enb`
- `core_mode_buf`  out  1  to core `modeBuffer` (0 load, 1 read)
- `core_reset_buf`  out  1  to core `resetBuff`, active-high pulse
- `core_pix`  out  DATA_W  to core `In_Arrary`
- `core_edges`  in  DATA_W  from core `Edges`
- `core_complete`  in  1  from core `complete`
- `out_valid`  out  1  edge value valid
- `out_data`  out  DATA_W  edge value
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse, image finished cleanly
- `error`  out  1  sticky watchdog flag; cleared by `start` or reset

## Operation
- All outputs are registered except `in_ready` and `busy`, which decode from state.
- Reset (async assert): state IDLE; `core_enb`, `core_mode_buf`, `out_valid`, `done`, `error`, `core_pix`, `out_data`, and counters = 0; `core_reset_buf` = 1 while `reset` is low.
- States: IDLE, CLEAR, LOAD, TURN, DRAIN, FINISH.
- IDLE: `start` -> CLEAR; clear `error`, pixel counter, drain counter.
- CLEAR: `core_reset_buf`=1 for exactly one cycle -> LOAD.
- LOAD: `in_ready`=1, `core_mode_buf`=0.
  - On accept (`in_valid & in_ready`): `core_pix<=in_data`, `core_enb<=1`, count++.
  - Without accept: `core_enb<=0`. The input stalls by gating `enb`; the core holds.
  - The accept that brings count to `NPIX` -> TURN. `in_ready`=0 from the next cycle.
- TURN: one cycle with `core_enb`=0, `core_mode_buf<=1` (mode change never coincides with enb high) -> DRAIN.
- DRAIN: `core_enb`=1, `core_mode_buf`=1.
  - Each cycle with `core_complete`=0: `out_valid<=1`, `out_data<=core_edges`, drain counter++.
  - `core_complete`=1 -> FINISH with `out_valid<=0` (the value that cycle is not forwarded).
  - Drain counter reaching `NPIX+WD_SLACK` without complete: `error<=1` -> FINISH.
- FINISH: `core_enb`=0, `core_mode_buf`=0. `done`=1 for one cycle only if `error`=0 -> IDLE.
- `abort` (any non-IDLE state, highest priority): next state CLEAR-then-IDLE path. Pulse `core_reset_buf` one cycle, zero `core_enb`/`out_valid`, no `done`, `error` unchanged.
- `start` outside IDLE is ignored. `start`+`abort` in IDLE: `abort` wins, no-op.
- Counters are sized `$clog2(NPIX+WD_SLACK+1)` and saturate; no wrap.

## Timing
- Pixel latency: `in_data` accepted at edge k appears on `core_pix` with `core_enb`=1 after edge k.
- Edge latency: `core_edges` sampled at edge k appears on `out_data`/`out_valid` after edge k.
- Minimum image time: 1 (CLEAR) + `NPIX` + 1 (TURN) + drain + 1 (FINISH) cycles.
- Throughput: one pixel per cycle with `in_valid` held high; no bubbles in LOAD.
- Reset deassertion: IDLE is entered synchronously; `core_reset_buf` drops at the first edge after release.

## Test plan
- Basic, `NPIX`=16: ramp 0..15 with `in_valid` always high, model core completes after 16 reads -> 16 `core_enb` load cycles, TURN gap visible, 16 `out_valid` beats matching model edges, `done` pulse, `error`=0.
- Input stalls: `in_valid` low every third cycle -> `core_enb` low exactly in the stall cycles, still 16 loads, identical output.
- Watchdog: model never asserts complete, `WD_SLACK`=4 -> `error`=1 after 20 drain beats, no `done`, IDLE reached.
- Abort mid-LOAD after 7 pixels -> one `core_reset_buf` pulse, `in_ready`=0, IDLE; next `start` reloads a full 16 pixels cleanly.
- Async reset asserted in DRAIN -> all outputs 0 immediately, `core_reset_buf`=1, no `done`; back-to-back images after release run correctly.
- `start` pulsed during LOAD and DRAIN -> ignored; exactly one `done` per image.
